// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling on an oversample tick, and a
// valid/read handshake with a one-clk framing-error pulse and a sticky overrun flag.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_clk_en,
  input  logic                 read_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_error,
  output logic                 overrun
);

  localparam int unsigned CntW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                 state_q;
  logic                   rx_meta_q, rx_s_q;
  logic [CntW-1:0]        cnt_q;
  logic [IdxW-1:0]        idx_q;
  logic [DATA_BITS-1:0]   sh_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q, frame_error_q, overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      cnt_q         <= '0;
      idx_q         <= '0;
      sh_q          <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      frame_error_q <= 1'b0;

      if (read_enable && rx_valid_q) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end

      // A capture below overrides the read clear above when both land on the same clk.
      if (rx_clk_en) begin
        case (state_q)
          StIdle: begin
            if (!rx_s_q) begin
              state_q <= StStart;
              cnt_q   <= '0;
            end
          end
          StStart: begin
            if (cnt_q == HalfLast) begin
              cnt_q <= '0;
              idx_q <= '0;
              state_q <= rx_s_q ? StIdle : StData;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StData: begin
            if (cnt_q == FullLast) begin
              sh_q  <= {rx_s_q, sh_q[DATA_BITS-1:1]};
              cnt_q <= '0;
              idx_q <= idx_q + IdxW'(1);
              if (idx_q == IdxLast) state_q <= StStop;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StStop: begin
            if (cnt_q == FullLast) begin
              state_q <= StIdle;
              cnt_q   <= '0;
              if (!rx_s_q) begin
                frame_error_q <= 1'b1;
              end else if (!rx_valid_q || read_enable) begin
                rx_data_q  <= sh_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q != StIdle);
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and randomised frames, expected bytes queued at send time and
// popped by an independent monitor whenever rx_valid rises.
module tb_uart_rx;

  localparam int BitClk = 64;

  logic       clk, rst, rx, rx_clk_en, read_enable;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_error, overrun;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_clk_en   (rx_clk_en),
    .read_enable (read_enable),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick every 4 clk, changed on the falling edge so it is stable at the active edge.
  logic [1:0] div;
  initial begin
    rx_clk_en = 1'b0;
    div = 2'd0;
    forever begin
      @(negedge clk);
      div = div + 2'd1;
      rx_clk_en = (div == 2'd0);
    end
  end

  int         n_cmp, n_bad;
  logic [7:0] exp_q[$];
  int         err_pending;
  logic       valid_m, overrun_m;
  logic [7:0] data_m;
  int         lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    do begin
      @(posedge clk);
      #1;
    end while (rx_clk_en != 1'b1);
  endtask

  // Reference model: a good frame delivers its byte if the holding slot is free, else it is lost.
  task automatic expect_frame(input logic [7:0] b, input logic good);
    if (!good) err_pending++;
    else if (!valid_m) begin
      exp_q.push_back(b);
      valid_m = 1'b1;
      data_m  = b;
    end else overrun_m = 1'b1;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clk(BitClk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == 4) begin
        wait_clk(BitClk / 2);
        check("busy_mid_frame", busy, 1);
        wait_clk(BitClk / 2);
      end else wait_clk(BitClk);
    end
    rx = stop_bit;
    wait_clk(BitClk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    expect_frame(b, stop_bit);
    drive_frame(b, stop_bit);
    if (!stop_bit) wait_clk(BitClk);
  endtask

  task automatic do_read();
    check("valid_before_read", rx_valid, valid_m);
    check("overrun_before_read", overrun, overrun_m);
    if (valid_m) check("data_before_read", rx_data, data_m);
    read_enable = 1'b1;
    wait_clk(1);
    read_enable = 1'b0;
    valid_m   = 1'b0;
    overrun_m = 1'b0;
    wait_clk(1);
    check("valid_after_read", rx_valid, 0);
    check("overrun_after_read", overrun, 0);
  endtask

  task automatic measure(output int l);
    l = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1;
      if (rx_valid) begin
        l = n;
        break;
      end
    end
  endtask

  // Monitor: pops the scoreboard on each rx_valid rise and accounts for frame_error pulses.
  logic       prev_v, prev_fe;
  logic [7:0] mon_e;
  initial begin
    prev_v  = 1'b0;
    prev_fe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rx_valid && !prev_v) begin
          check("capture_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("rx_data_capture", rx_data, mon_e);
          end
        end
        if (prev_fe) check("frame_error_width", frame_error, 0);
        else if (frame_error) begin
          check("frame_error_expected", err_pending != 0, 1);
          if (err_pending > 0) err_pending--;
        end
      end
      prev_v  = rx_valid;
      prev_fe = frame_error;
    end
  end

  initial begin
    #3ms;
    $display("FAIL timeout: bench did not finish (compared %0d)", n_cmp);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] b;
    logic       good;
    logic [7:0] lb[4];
    rst = 1'b1; rx = 1'b1; read_enable = 1'b0;
    n_cmp = 0; n_bad = 0; err_pending = 0;
    valid_m = 1'b0; overrun_m = 1'b0; data_m = 8'h00;
    wait_clk(5);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_error", frame_error, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b0;
    wait_clk(10);

    // Single byte with latency measurement; the same alignment is reused later.
    align();
    fork
      send_frame(8'hA5, 1'b1);
      measure(lat);
    join
    check("a5_latency_window", (lat >= 600) && (lat <= 620), 1);
    do_read();

    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h80; lb[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      send_frame(lb[i], 1'b1);
      do_read();
    end

    // Short low glitch on an idle line.
    rx = 1'b0;
    wait_clk(10);
    check("glitch_busy_high", busy, 1);
    wait_clk(10);
    rx = 1'b1;
    wait_clk(40);
    check("glitch_busy_low", busy, 0);
    check("glitch_no_valid", rx_valid, 0);
    wait_clk(BitClk);

    // Bad stop bit: byte dropped, old data kept.
    send_frame(8'h3C, 1'b0);
    check("fe_valid_stays_low", rx_valid, valid_m);
    check("fe_data_kept", rx_data, data_m);
    check("fe_pulse_seen", err_pending, 0);

    // Overrun.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("overrun_data_kept", rx_data, 8'h11);
    check("overrun_set", overrun, overrun_m);
    do_read();

    // Reset in the middle of a frame.
    b = 8'h5A;
    rx = 1'b0;
    wait_clk(BitClk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_clk(BitClk);
    end
    rx = b[4];
    wait_clk(BitClk / 2);
    rst = 1'b1;
    wait_clk(2);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_error", frame_error, 0);
    check("midrst_overrun", overrun, 0);
    rx = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    valid_m = 1'b0; overrun_m = 1'b0; data_m = 8'h00;
    wait_clk(BitClk);
    send_frame(8'hC3, 1'b1);
    do_read();

    // Read coincident with capture while an overrun is pending: capture wins.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    b = 8'($urandom);
    align();
    fork
      drive_frame(b, 1'b1);
      begin
        wait_clk(lat - 1);
        read_enable = 1'b1;
        wait_clk(1);
        read_enable = 1'b0;
      end
    join
    valid_m = 1'b1; data_m = b; overrun_m = 1'b0;
    check("coincide_valid", rx_valid, 1);
    check("coincide_data", rx_data, b);
    check("coincide_overrun", overrun, 0);
    do_read();

    // Randomised traffic.
    for (int k = 0; k < 40; k++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      send_frame(b, good);
      if ($urandom_range(0, 3) != 0) do_read();
      wait_clk($urandom_range(0, 100));
    end
    do_read();

    wait_clk(100);
    check("scoreboard_drained", exp_q.size(), 0);
    check("frame_errors_drained", err_pending, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
